// File: rtl/lr_pkg.sv
// Shared definitions for the online linear-regression trainer.
// - Word format is signed Q8.8 (WORD_W=16, FRAC=8).
// - ACC_W is the width of the dot-product accumulator and of every
//   intermediate value handed to sat16.
// - sat16 clamps a wide signed value into the 16-bit range 0x8000..0x7FFF.
// - sext widens a 16-bit signed word to ACC_W bits.
package lr_pkg;

   localparam int WORD_W       = 16;
   localparam int FRAC         = 8;
   localparam int NUM_FEATURES = 6;
   localparam int FRAME_W      = WORD_W * (NUM_FEATURES + 1);
   localparam int NUM_DP       = 6;
   localparam int LR_SHIFT     = 4;
   localparam int ACC_W        = 40;
   localparam int PROD_W       = 2 * WORD_W;
   localparam int IDX_W        = 3;
   localparam int CNT_W        = 7;
   localparam int FCNT_W       = 3;

   typedef enum logic [2:0] {
      RECV = 3'd0,
      PRED = 3'd1,
      ERR  = 3'd2,
      UPD  = 3'd3,
      DONE = 3'd4
   } lr_state_t;

   function automatic logic signed [WORD_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
      logic signed [WORD_W-1:0] r_s;
      if (v > 40'sh0000007FFF) begin
         r_s = 16'sh7FFF;
      end else if (v < 40'shFFFFFF8000) begin
         r_s = 16'sh8000;
      end else begin
         r_s = v[WORD_W-1:0];
      end
      return r_s;
   endfunction

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [WORD_W-1:0] v);
      return ACC_W'(v);
   endfunction

endpackage

// File: rtl/lr_if.sv
// Bus between the training-data source and the trainer.
// - ser   : serial training data, one bit per rising CLK edge, MSB first
// - w_sel : weight read index (NUM_FEATURES selects the bias)
// - w_out : selected weight, Q8.8
// - done  : training complete, sticky
// master = data source / reader, slave = lr_main.
interface lr_if;
   import lr_pkg::*;

   logic              ser;
   logic [IDX_W-1:0]  w_sel;
   logic [WORD_W-1:0] w_out;
   logic              done;

   modport master (output ser, output w_sel, input w_out, input done);
   modport slave  (input ser, input w_sel, output w_out, output done);

endinterface

// File: rtl/lr_deser.sv
// Serial-to-parallel front end of the trainer.
// Shifts ser in MSB first and counts bits down from FRAME_W-1 to 0.
// On the bit-0 edge, frame presents the complete frame (the last bit is
// taken straight from ser) and frame_vld is high for that one cycle, so
// the consumer can latch the frame on the same edge that samples bit 0.
// Ports:
// - CLK, RST_N : clock, synchronous active-low reset
// - ser        : serial input
// - frame      : assembled frame, valid while frame_vld is high
// - frame_vld  : high during the cycle whose edge samples bit 0
module lr_deser
   import lr_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               ser,
   output logic [FRAME_W-1:0] frame,
   output logic               frame_vld
);

   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FRAME_W - 1);

   logic [FRAME_W-2:0] shift_r;
   logic [CNT_W-1:0]   cnt_r;

   // Shift register and bit down-counter; reset discards any partial frame.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         shift_r <= '0;
         cnt_r   <= CNT_TOP;
      end else begin
         shift_r <= {shift_r[FRAME_W-3:0], ser};
         if (cnt_r == 7'd0) begin
            cnt_r <= CNT_TOP;
         end else begin
            cnt_r <= cnt_r - 7'd1;
         end
      end
   end

   assign frame     = {shift_r, ser};
   assign frame_vld = (cnt_r == 7'd0);

endmodule

// File: rtl/lr_main.sv
// Online linear-regression (LMS/SGD) trainer.
// Each serial frame carries a label y and NUM_FEATURES features x_i.
// Per frame: pred = sat16(sum(w_i*x_i) >>> FRAC), err = sat16(y - pred),
// w_i <= sat16(w_i + sat16((err*x_i) >>> (FRAC+LR_SHIFT))).
// One shared 16x16 multiplier is time-multiplexed: PRED uses it for w_i*x_i,
// UPD for err*x_i. After NUM_DP frames the trainer freezes and raises done.
// Optional feature macro: LR_BIAS_EN adds a trained bias b (read at
// w_sel = NUM_FEATURES); without it that index reads 0.
// Ports:
// - CLK   : rising-edge clock
// - RST_N : synchronous active-low reset
// - bus   : lr_if slave (ser, w_sel in; w_out, done out)
module lr_main
   import lr_pkg::*;
(
   input logic CLK,
   input logic RST_N,
   lr_if.slave bus
);

   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_FEATURES - 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(NUM_DP - 1);

   logic [FRAME_W-1:0]        frame_s;
   logic                      frame_vld_s;

   lr_state_t                 state_r;
   logic [IDX_W-1:0]          idx_r;
   logic [FCNT_W-1:0]         frame_cnt_r;
   logic [FRAME_W-1:0]        hold_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic signed [WORD_W-1:0]  err_r;
   logic signed [WORD_W-1:0]  w_r [NUM_FEATURES];
   logic                      done_r;

   logic signed [WORD_W-1:0]  b_s;
   logic signed [WORD_W-1:0]  y_s;
   logic signed [WORD_W-1:0]  x_s;
   logic signed [WORD_W-1:0]  w_cur_s;
   logic signed [WORD_W-1:0]  mul_a_s;
   logic signed [PROD_W-1:0]  prod_s;
   logic signed [ACC_W-1:0]   acc_nxt_s;
   logic signed [WORD_W-1:0]  pred_s;
   logic signed [WORD_W-1:0]  pred_b_s;
   logic signed [WORD_W-1:0]  err_nxt_s;
   logic signed [WORD_W-1:0]  dw_s;
   logic signed [WORD_W-1:0]  w_nxt_s;
   logic [WORD_W-1:0]         rd_s;

   lr_deser u_deser (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ser       (bus.ser),
      .frame     (frame_s),
      .frame_vld (frame_vld_s)
   );

   // Operand fetch from the held frame; x_k sits at bits [16k+15:16k].
   assign y_s = hold_r[FRAME_W-1 -: WORD_W];
   assign x_s = hold_r[{idx_r, 4'b0000} +: WORD_W];

   // Current weight selected by the step index.
   always_comb begin
      w_cur_s = '0;
      case (idx_r)
         3'd0:    w_cur_s = w_r[0];
         3'd1:    w_cur_s = w_r[1];
         3'd2:    w_cur_s = w_r[2];
         3'd3:    w_cur_s = w_r[3];
         3'd4:    w_cur_s = w_r[4];
         3'd5:    w_cur_s = w_r[5];
         default: w_cur_s = '0;
      endcase
   end

   // Shared multiplier: weight during PRED, latched error during UPD.
   assign mul_a_s   = (state_r == PRED) ? w_cur_s : err_r;
   assign prod_s    = PROD_W'(mul_a_s) * PROD_W'(x_s);
   assign acc_nxt_s = acc_r + ACC_W'(prod_s);

   // Error path, evaluated in ERR from the finished accumulator.
   assign pred_s    = sat16(acc_r >>> FRAC);
   assign pred_b_s  = sat16(sext(pred_s) + sext(b_s));
   assign err_nxt_s = sat16(sext(y_s) - sext(pred_b_s));

   // Weight update path, evaluated in UPD.
   assign dw_s    = sat16(ACC_W'(prod_s) >>> (FRAC + LR_SHIFT));
   assign w_nxt_s = sat16(sext(w_cur_s) + sext(dw_s));

   // Training FSM: frame capture, dot product, error, weight update, done.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r     <= RECV;
         idx_r       <= '0;
         frame_cnt_r <= '0;
         hold_r      <= '0;
         acc_r       <= '0;
         err_r       <= '0;
         done_r      <= 1'b0;
         for (int i = 0; i < NUM_FEATURES; i++) begin
            w_r[i] <= '0;
         end
      end else begin
         case (state_r)
            RECV: begin
               if (frame_vld_s) begin
                  hold_r  <= frame_s;
                  acc_r   <= '0;
                  idx_r   <= '0;
                  state_r <= PRED;
               end
            end
            PRED: begin
               acc_r <= acc_nxt_s;
               if (idx_r == IDX_LAST) begin
                  idx_r   <= '0;
                  state_r <= ERR;
               end else begin
                  idx_r <= idx_r + 3'd1;
               end
            end
            ERR: begin
               err_r   <= err_nxt_s;
               state_r <= UPD;
            end
            UPD: begin
               for (int i = 0; i < NUM_FEATURES; i++) begin
                  if (idx_r == IDX_W'(i)) begin
                     w_r[i] <= w_nxt_s;
                  end
               end
               if (idx_r == IDX_LAST) begin
                  idx_r <= '0;
                  if (frame_cnt_r == FCNT_LAST) begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     frame_cnt_r <= frame_cnt_r + 3'd1;
                     state_r     <= RECV;
                  end
               end else begin
                  idx_r <= idx_r + 3'd1;
               end
            end
            DONE: begin
               state_r <= DONE;
            end
            default: begin
               state_r <= RECV;
            end
         endcase
      end
   end

`ifdef LR_BIAS_EN
   logic signed [WORD_W-1:0] b_r;
   logic signed [WORD_W-1:0] b_nxt_s;

   assign b_nxt_s = sat16(sext(b_r) + (sext(err_r) >>> LR_SHIFT));

   // Bias register: updated once per frame, on the first UPD cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         b_r <= '0;
      end else if ((state_r == UPD) && (idx_r == 3'd0)) begin
         b_r <= b_nxt_s;
      end else begin
         b_r <= b_r;
      end
   end

   assign b_s = b_r;
`else
   assign b_s = '0;
`endif

   // Weight read port; index NUM_FEATURES is the bias, anything above reads 0.
   always_comb begin
      rd_s = '0;
      case (bus.w_sel)
         3'd0:    rd_s = w_r[0];
         3'd1:    rd_s = w_r[1];
         3'd2:    rd_s = w_r[2];
         3'd3:    rd_s = w_r[3];
         3'd4:    rd_s = w_r[4];
         3'd5:    rd_s = w_r[5];
         3'd6:    rd_s = b_s;
         default: rd_s = '0;
      endcase
   end

   assign bus.w_out = rd_s;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_lr_main.sv
module tb_lr_main;
   import lr_pkg::*;

   typedef logic [15:0] xv_t [NUM_FEATURES];

   typedef struct {
      logic [2:0]  sel;
      logic [15:0] exp;
   } rd_t;

   typedef struct {
      logic        rst_before;
      logic [15:0] y;
      logic [15:0] x0;
      logic [15:0] exp_w0;
      logic [15:0] exp_b;
   } vec_t;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   lr_if bus();

   lr_main dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int mw [NUM_FEATURES];
   int mb;
   int mcnt;
   bit mod_pend;
   bit dir_pend;
   logic [15:0] dir_exp_w0;
   logic [15:0] dir_exp_b;

   int edge_cnt  = 0;
   int done_edge = 0;

   rd_t  rst_tab [8];
   vec_t vecs [4];

   // edge counter since reset release and the edge where done first rose
   always @(posedge CLK) begin
      if (!RST_N) begin
         edge_cnt  = 0;
         done_edge = 0;
      end else begin
         edge_cnt = edge_cnt + 1;
         #1;
         if (bus.done && done_edge == 0) done_edge = edge_cnt;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int msat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_FEATURES; i++) mw[i] = 0;
      mb = 0;
      mcnt = 0;
      mod_pend = 0;
      dir_pend = 0;
   endfunction

   function automatic void model_frame(input logic [15:0] y, input xv_t x);
      longint acc;
      int pred;
      int err;
      if (mcnt >= NUM_DP) return;
      acc = 0;
      for (int i = 0; i < NUM_FEATURES; i++)
         acc += longint'(mw[i]) * longint'($signed(x[i]));
      pred = msat(acc >>> FRAC);
`ifdef LR_BIAS_EN
      pred = msat(longint'(pred) + longint'(mb));
`endif
      err = msat(longint'($signed(y)) - longint'(pred));
      for (int i = 0; i < NUM_FEATURES; i++)
         mw[i] = msat(longint'(mw[i]) +
                      longint'(msat((longint'(err) * longint'($signed(x[i]))) >>> (FRAC + LR_SHIFT))));
`ifdef LR_BIAS_EN
      mb = msat(longint'(mb) + longint'(err >>> LR_SHIFT));
`endif
      mcnt++;
   endfunction

   function automatic logic [15:0] exp_rd(input int s);
      if (s < NUM_FEATURES) return 16'(mw[s]);
`ifdef LR_BIAS_EN
      if (s == NUM_FEATURES) return 16'(mb);
`endif
      return 16'h0000;
   endfunction

   function automatic logic [FRAME_W-1:0] mk_frame(input logic [15:0] y, input xv_t x);
      logic [FRAME_W-1:0] f;
      f[FRAME_W-1 -: 16] = y;
      for (int k = 0; k < NUM_FEATURES; k++) f[16*k +: 16] = x[k];
      return f;
   endfunction

   // called in the low clock phase; pos = edges since the current frame began
   task automatic pend_step(input int pos);
      int sel;
      if (pos == 18 && dir_pend) begin
         bus.w_sel = 3'd6; #1;
         check("dir_bias", bus.w_out, dir_exp_b);
      end
      if (pos == 19 && dir_pend) begin
         bus.w_sel = 3'd0; #1;
         check("dir_w0", bus.w_out, dir_exp_w0);
         dir_pend = 0;
      end
      if (pos >= 20 && pos < 28 && mod_pend) begin
         sel = pos - 20;
         bus.w_sel = 3'(sel); #1;
         check($sformatf("model_w%0d", sel), bus.w_out, exp_rd(sel));
         if (sel == 0) check("model_done", bus.done, (mcnt >= NUM_DP) ? 1 : 0);
         if (sel == 7) mod_pend = 0;
      end
   endtask

   task automatic send_frame(input logic [FRAME_W-1:0] f, input int abort_at);
      for (int i = FRAME_W - 1; i >= 0; i--) begin
         bus.ser = f[i];
         if (i == abort_at) begin
            bus.w_sel = 3'd0;
            RST_N = 1'b0;
            @(posedge CLK); #1;
            check($sformatf("abort%0d_w0", abort_at), bus.w_out, 0);
            check($sformatf("abort%0d_done", abort_at), bus.done, 0);
            @(negedge CLK);
            RST_N = 1'b1;
            model_reset();
            return;
         end
         pend_step(FRAME_W - 1 - i);
         @(negedge CLK);
      end
   endtask

   task automatic feed(input logic [15:0] y, input xv_t x);
      send_frame(mk_frame(y, x), -1);
      model_frame(y, x);
      mod_pend = 1;
   endtask

   task automatic tail_check();
      for (int c = 0; c < 28; c++) begin
         bus.ser = 1'b0;
         pend_step(c);
         @(negedge CLK);
      end
   endtask

   task automatic do_reset(input bit with_tab);
      @(negedge CLK);
      RST_N = 1'b0;
      bus.ser = 1'b0;
      @(negedge CLK);
      if (with_tab) begin
         for (int t = 0; t < 8; t++) begin
            bus.w_sel = rst_tab[t].sel; #1;
            check($sformatf("rst_w%0d", t), bus.w_out, rst_tab[t].exp);
            @(negedge CLK);
         end
         check("rst_done", bus.done, 0);
      end
      RST_N = 1'b1;
      model_reset();
   endtask

   initial begin
      xv_t zx;
      xv_t xv;
      bus.ser = 1'b0;
      bus.w_sel = 3'd0;
      for (int i = 0; i < NUM_FEATURES; i++) zx[i] = 16'h0000;
      model_reset();

      for (int t = 0; t < 8; t++) begin
         rst_tab[t].sel = 3'(t);
         rst_tab[t].exp = 16'h0000;
      end
      vecs[0] = '{1'b1, 16'h0100, 16'h0100, 16'h0010, 16'h0000};
      vecs[1] = '{1'b0, 16'h0100, 16'h0100, 16'h001F, 16'h0000};
      vecs[2] = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
      vecs[3] = '{1'b0, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
`ifdef LR_BIAS_EN
      vecs[0].exp_b = 16'h0010;
      vecs[1].exp_w0 = 16'h001E;
      vecs[1].exp_b = 16'h001E;
      vecs[2].exp_b = 16'h07FF;
      vecs[3].exp_b = 16'hFFFF;
`endif

      // reset state, then six all-zero frames and done timing
      do_reset(1'b1);
      for (int k = 0; k < NUM_DP; k++) feed(16'h0000, zx);
      tail_check();
      check("done_edge", done_edge, 6 * FRAME_W + 13);
      xv = zx; xv[0] = 16'h0100;
      feed(16'h0100, xv);
      tail_check();

      // directed vectors: LMS steps and saturation
      for (int k = 0; k < 4; k++) begin
         if (vecs[k].rst_before) begin
            if (k > 0) tail_check();
            do_reset(1'b0);
         end
         xv = zx; xv[0] = vecs[k].x0;
         feed(vecs[k].y, xv);
         dir_pend = 1;
         dir_exp_w0 = vecs[k].exp_w0;
         dir_exp_b = vecs[k].exp_b;
      end
      tail_check();

      // reset during compute, reset mid-frame, realignment afterwards
      do_reset(1'b0);
      xv = zx; xv[0] = 16'h0100;
      feed(16'h0100, xv);
      feed(16'h0100, xv);
      send_frame(mk_frame(16'h0200, xv), 108);
      feed(16'h0100, xv);
      feed(16'h0100, xv);
      send_frame(mk_frame(16'h0200, xv), 50);
      feed(16'h0100, xv);
      dir_pend = 1;
      dir_exp_w0 = 16'h0010;
`ifdef LR_BIAS_EN
      dir_exp_b = 16'h0010;
`else
      dir_exp_b = 16'h0000;
`endif
      tail_check();

      // randomized training runs against the reference model
      for (int b = 0; b < 2; b++) begin
         do_reset(1'b0);
         for (int k = 0; k < NUM_DP; k++) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
               if (b == 0) xv[i] = 16'($urandom_range(0, 1023)) - 16'd512;
               else        xv[i] = 16'($urandom);
            end
            feed(16'($urandom), xv);
         end
         tail_check();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
